// File: rtl/td4w_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4w_pkg : opcodes and operand-select encodings shared by the td4w core
// rev 1.0
// ---------------------------------------------------------------------------
package td4w_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_ADD_A_B  = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_A    = 4'b1010;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JZ       = 4'b1100;
  localparam logic [3:0] OP_HALT     = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    IMM_DAT  = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_B    = 2'd2
  } imm_sel_e;

endpackage

`default_nettype wire

// File: rtl/td4w_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4w_alu : DW-bit adder with carry-out and zero detect (combinational)
// rev 1.0
// ---------------------------------------------------------------------------
module td4w_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] r,
  output logic          carry,
  output logic          zero
);

  assign {carry, r} = {1'b0, src} + {1'b0, imm};
  assign zero       = (r == '0);

endmodule

`default_nettype wire

// File: rtl/td4w_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4w_core : parametrised TD4-style accumulator CPU core with stall and halt
// rev 1.0
// ---------------------------------------------------------------------------
module td4w_core
  import td4w_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] io_in,
  output logic [DW-1:0] io_out,
  output logic          io_wr,
  output logic [AW-1:0] adr,
  input  logic [DW+3:0] dat,
  input  logic          dat_valid,
  output logic          halted
);

  logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          c_q, c_d, z_q, z_d, halted_q, halted_d, io_wr_q, io_wr_d;

  logic [3:0]    op;
  logic [DW-1:0] imm;
  logic [AW-1:0] jmp_target;

  src_sel_e      src_sel;
  imm_sel_e      imm_sel;
  logic          wr_a, wr_b, wr_out, take_jmp, is_halt;
  logic [DW-1:0] out_val, alu_src, alu_imm, alu_r;
  logic          alu_carry, alu_zero, exec;

  assign op   = dat[DW+3:DW];
  assign imm  = dat[DW-1:0];
  assign exec = dat_valid && !halted_q;

  if (AW > DW) begin : g_tgt_ext
    assign jmp_target = {{(AW-DW){1'b0}}, imm};
  end else begin : g_tgt_trunc
    assign jmp_target = imm[AW-1:0];
  end

  // Decode; jump conditions look at the flags left by the previous instruction.
  always_comb begin
    src_sel  = SRC_ZERO;
    imm_sel  = IMM_DAT;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    wr_out   = 1'b0;
    out_val  = imm;
    take_jmp = 1'b0;
    is_halt  = 1'b0;
    case (op)
      OP_ADD_A_IM: begin src_sel = SRC_A;  wr_a = 1'b1; end
      OP_MOV_A_B:  begin src_sel = SRC_B;  imm_sel = IMM_ZERO; wr_a = 1'b1; end
      OP_IN_A:     begin src_sel = SRC_IN; imm_sel = IMM_ZERO; wr_a = 1'b1; end
      OP_MOV_A_IM: wr_a = 1'b1;
      OP_MOV_B_A:  begin src_sel = SRC_A;  imm_sel = IMM_ZERO; wr_b = 1'b1; end
      OP_ADD_B_IM: begin src_sel = SRC_B;  wr_b = 1'b1; end
      OP_IN_B:     begin src_sel = SRC_IN; imm_sel = IMM_ZERO; wr_b = 1'b1; end
      OP_MOV_B_IM: wr_b = 1'b1;
      OP_ADD_A_B:  begin src_sel = SRC_A;  imm_sel = IMM_B; wr_a = 1'b1; end
      OP_OUT_B:    begin wr_out = 1'b1; out_val = b_q; end
      OP_OUT_A:    begin wr_out = 1'b1; out_val = a_q; end
      OP_OUT_IM:   wr_out = 1'b1;
      OP_JZ:       take_jmp = z_q;
      OP_HALT:     is_halt = 1'b1;
      OP_JNC:      take_jmp = !c_q;
      OP_JMP:      take_jmp = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    alu_src = '0;
    case (src_sel)
      SRC_A:   alu_src = a_q;
      SRC_B:   alu_src = b_q;
      SRC_IN:  alu_src = io_in;
      default: alu_src = '0;
    endcase
    alu_imm = imm;
    case (imm_sel)
      IMM_ZERO: alu_imm = '0;
      IMM_B:    alu_imm = b_q;
      default:  alu_imm = imm;
    endcase
  end

  td4w_alu #(.DW(DW)) u_alu (
    .src   (alu_src),
    .imm   (alu_imm),
    .r     (alu_r),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    pc_d     = pc_q;
    c_d      = c_q;
    z_d      = z_q;
    halted_d = halted_q;
    io_wr_d  = 1'b0;
    if (exec) begin
      if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        c_d  = alu_carry;
        z_d  = alu_zero;
        pc_d = take_jmp ? jmp_target : pc_q + AW'(1);
        if (wr_a)   a_d   = alu_r;
        if (wr_b)   b_d   = alu_r;
        if (wr_out) out_d = out_val;
        io_wr_d = wr_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
      io_wr_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      pc_q     <= pc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      halted_q <= halted_d;
      io_wr_q  <= io_wr_d;
    end
  end

  assign adr    = pc_q;
  assign io_out = out_q;
  assign io_wr  = io_wr_q;
  assign halted = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_td4w_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_td4w_core : scoreboard bench for td4w_core (DW=8, AW=6)
// rev 1.0
// ---------------------------------------------------------------------------
module tb_td4w_core;
  import td4w_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] io_in = '0;
  logic [DW-1:0] io_out;
  logic          io_wr;
  logic [AW-1:0] adr;
  logic [DW+3:0] dat;
  logic          dat_valid = 1'b0;
  logic          halted;

  logic [DW+3:0] rom [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  // reference machine state
  int m_a, m_b, m_out, m_pc, m_c, m_z, m_halt, m_iowr;
  int exp_q[$];

  always #5 clk = ~clk;

  assign dat = rom[adr];

  td4w_core #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_wr     (io_wr),
    .adr       (adr),
    .dat       (dat),
    .dat_valid (dat_valid),
    .halted    (halted)
  );

  function automatic logic [DW+3:0] ins(input logic [3:0] op, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, v[DW-1:0]};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = ins(OP_HALT, 0);
  endtask

  // Instruction-level reference: what one rising edge does to the machine.
  task automatic model_step(input bit r, input bit v, input int iin);
    logic [DW+3:0] w;
    int op, imm, res, dest;
    bit jmp;
    m_iowr = 0;
    if (r) begin
      m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0; m_z = 0; m_halt = 0;
    end else if (v && m_halt == 0) begin
      w    = rom[m_pc];
      op   = int'(w[DW+3:DW]);
      imm  = int'(w[DW-1:0]);
      res  = imm;
      dest = 0;
      jmp  = 0;
      case (op)
        0:  begin res = m_a + imm; dest = 1; end
        1:  begin res = m_b;       dest = 1; end
        2:  begin res = iin;       dest = 1; end
        3:  begin res = imm;       dest = 1; end
        4:  begin res = m_a;       dest = 2; end
        5:  begin res = m_b + imm; dest = 2; end
        6:  begin res = iin;       dest = 2; end
        7:  begin res = imm;       dest = 2; end
        8:  begin res = m_a + m_b; dest = 1; end
        9:  begin m_out = m_b; m_iowr = 1; end
        10: begin m_out = m_a; m_iowr = 1; end
        11: begin m_out = imm; m_iowr = 1; end
        12: jmp = (m_z != 0);
        14: jmp = (m_c == 0);
        15: jmp = 1;
        default: ;
      endcase
      if (op == 13) begin
        m_halt = 1;
      end else begin
        if (dest == 1) m_a = res % (1 << DW);
        if (dest == 2) m_b = res % (1 << DW);
        m_c  = (res >= (1 << DW)) ? 1 : 0;
        m_z  = ((res % (1 << DW)) == 0) ? 1 : 0;
        m_pc = jmp ? (imm % DEPTH) : ((m_pc + 1) % DEPTH);
        if (m_iowr != 0) exp_q.push_back(m_out);
      end
    end
  endtask

  task automatic step(input bit r, input bit v);
    @(negedge clk);
    rst       = r;
    dat_valid = v;
    io_in     = DW'($urandom);
    model_step(r, v, int'(io_in));
    @(posedge clk);
    #1;
    checks++;
    if (int'(adr) != m_pc) begin
      errors++;
      $display("FAIL adr: got %0h, expected %0h", adr, m_pc);
    end
    checks++;
    if (int'(halted) != m_halt) begin
      errors++;
      $display("FAIL halted: got %0d, expected %0d", halted, m_halt);
    end
    checks++;
    if (int'(io_wr) != m_iowr) begin
      errors++;
      $display("FAIL io_wr: got %0d, expected %0d", io_wr, m_iowr);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  // Monitor: every write strobe must match the oldest outstanding OUT value.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (io_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL io_out_unexpected: got write of %0h, expected no write", io_out);
        end else begin
          e = exp_q.pop_front();
          if (int'(io_out) != e) begin
            errors++;
            $display("FAIL io_out: got %0h, expected %0h", io_out, e);
          end
        end
      end
    end
  end

  initial begin
    int op;
    clear_rom();

    // Counter across the full address space, PC wrap, output of A.
    for (int i = 0; i < DEPTH - 1; i++) rom[i] = ins(OP_ADD_A_IM, 1);
    rom[DEPTH-1] = ins(OP_OUT_A, 0);
    step(1'b1, 1'b0);
    run(200);

    // JNC loop until A overflows, then a single OUT Im.
    clear_rom();
    rom[0] = ins(OP_ADD_A_IM, 1);
    rom[1] = ins(OP_JNC, 0);
    rom[2] = ins(OP_OUT_IM, 'hA);
    step(1'b1, 1'b1);
    run(530);

    // ADD A,B overflow sets Z, JZ to top address, truncated JMP target.
    clear_rom();
    rom[0]       = ins(OP_MOV_B_IM, 1);
    rom[1]       = ins(OP_MOV_A_IM, 'hFF);
    rom[2]       = ins(OP_ADD_A_B, 0);
    rom[3]       = ins(OP_JZ, 'h3F);
    rom[4]       = ins(OP_OUT_IM, 'h11);
    rom[5]       = ins(OP_OUT_A, 0);
    rom[DEPTH-1] = ins(OP_JMP, 'hC5);
    step(1'b1, 1'b1);
    run(10);

    // Stall during OUT B.
    clear_rom();
    rom[0] = ins(OP_MOV_B_IM, 'h5A);
    rom[1] = ins(OP_OUT_B, 0);
    rom[2] = ins(OP_OUT_B, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    run(4);

    // HALT is sticky; reset recovers.
    clear_rom();
    rom[0] = ins(OP_MOV_A_IM, 3);
    rom[1] = ins(OP_HALT, 0);
    rom[2] = ins(OP_MOV_A_IM, 7);
    rom[3] = ins(OP_OUT_A, 0);
    step(1'b1, 1'b1);
    run(6);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Carry set by ADD, cleared by IN; JNC observes it.
    clear_rom();
    rom[0] = ins(OP_MOV_A_IM, 1);
    rom[1] = ins(OP_ADD_A_IM, 'hFF);
    rom[2] = ins(OP_JNC, 9);
    rom[3] = ins(OP_IN_B, 0);
    rom[4] = ins(OP_JNC, 7);
    rom[5] = ins(OP_OUT_IM, 'hEE);
    rom[7] = ins(OP_OUT_B, 0);
    rom[9] = ins(OP_OUT_IM, 'h99);
    step(1'b1, 1'b1);
    run(8);

    // Random programs with random stalls, inputs and occasional reset.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < DEPTH; i++) begin
        op = $urandom_range(0, 15);
        if (op == 13 && $urandom_range(0, 7) != 0) op = 10;
        rom[i] = ins(op[3:0], int'($urandom));
      end
      step(1'b1, 1'b1);
      for (int k = 0; k < 180; k++)
        step($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0);
    end

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL io_wr_missing: got %0d outstanding writes, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/td4w_core.md
# td4w_core

Parametrised successor to the 4-bit TD4 CPU core: same accumulator/ROM-fed architecture (registers A and B, output port, program counter, carry flag), but with configurable data and address width. It adds a zero flag, new opcodes (ADD A,B, OUT A, JZ, HALT), a ROM-ready stall input and an output-write strobe. It sits between the instruction ROM (driven from `adr`, returning `dat`) and the board I/O pins.

## Interface
- `DW`, 4, data/register/immediate width (≥4)
- `AW`, 4, program counter / ROM address width (≥2)
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `io_in`  in  DW  input port, sampled by IN instructions
- `io_out`  out  DW  output port register
- `io_wr`  out  1  one-cycle pulse, registered, high in the cycle after `io_out` is written
- `adr`  out  AW  ROM address, equals PC
- `dat`  in  DW+4  instruction word: opcode `dat[DW+3:DW]`, immediate `dat[DW-1:0]`
- `dat_valid`  in  1  ROM data valid; low stalls the core
- `halted`  out  1  core stopped by HALT

## Operation
- State: A, B (DW), OUT (DW), PC (AW), C, Z (1 each), halted.
- Reset: A=B=OUT=0, PC=0, C=0, Z=0, `io_wr`=0, `halted`=0; `adr`=0 in the first cycle after reset.
- One instruction executes per cycle when `dat_valid`=1 and `halted`=0. Otherwise nothing changes (PC, registers and flags hold), and `io_wr`=0.
- ALU: `{C_next, R} = src + imm` (DW-bit add, carry-out to C). `Z_next = (R==0)`. Src is A, B, io_in or 0, selected per opcode.
- Opcodes, with src and action:
  - 0000 ADD A,Im: src A; A←R
  - 0001 MOV A,B: src B, imm forced 0; A←R
  - 0010 IN A: src io_in, imm forced 0; A←R
  - 0011 MOV A,Im: src 0; A←R
  - 0100 MOV B,A: src A, imm forced 0; B←R
  - 0101 ADD B,Im: src B; B←R
  - 0110 IN B: src io_in, imm forced 0; B←R
  - 0111 MOV B,Im: src 0; B←R
  - 1000 ADD A,B: src A, operand B in place of imm; A←R
  - 1001 OUT B: OUT←B
  - 1010 OUT A: OUT←A
  - 1011 OUT Im: OUT←imm
  - 1100 JZ Im: if Z, PC←target
  - 1101 HALT: halted←1; PC holds
  - 1110 JNC Im: if !C, PC←target
  - 1111 JMP Im: PC←target
- Flag updates:
  - C and Z update on every executed non-HALT instruction, including OUT and jumps, where src=0 and R=imm. This preserves TD4 semantics: C clears after any non-add instruction.
  - Jump conditions use C/Z values from before the current instruction.
- Jump target: imm zero-extended to AW if AW>DW, truncated to its low AW bits if AW<DW.
- PC increments by 1 modulo 2^AW when no jump is taken. PC=2^AW−1 wraps to 0.
- HALT is sticky until `rst`. Once halted, `adr` holds the HALT address.

## Timing
- Single-cycle execute: result visible in registers the edge after the instruction is presented with `dat_valid`=1.
- `io_out` updates at that edge; `io_wr` is high for exactly the following cycle. Back-to-back OUT instructions give a continuous `io_wr`.
- `adr` is combinational from PC only (registered source); no path from `dat` to `adr` within a cycle.
- Reset asserted mid-program: the next edge forces the reset state regardless of `dat_valid`/`halted`. Reset overrides execution in the same cycle.
- A stall (`dat_valid`=0) during an OUT cycle suppresses both the write and `io_wr`.

## Structure
- Package `td4w_pkg`: 4-bit opcode localparams (OP_ADD_A_IM … OP_JMP) and the src-select enum (SRC_A, SRC_B, SRC_IN, SRC_ZERO).
- Sub-module `td4w_alu` (parameter DW): operands src and imm, outputs R, carry, zero; purely combinational.
- Core: decode, register/flag update, PC logic, halt/stall control.

## Test plan
- Reset, DW=4: program `ADD A,1` ×16 → A counts 1..15, 0. C=1 and Z=1 only after the 16th instruction. PC wraps 15→0.
- JNC loop, DW=4: `ADD A,1; JNC 0; OUT Im 0xA` → loops until A overflows, then `io_out`=0xA with a single `io_wr` pulse.
- DW=8, AW=6: `MOV A,0xFF; ADD A,B` with B=1 via `MOV B,1` → A=0x00, C=1, Z=1. `JZ 0x3F` jumps to PC=0x3F. A target of 0xC5 truncates to 0x05.
- Stall: hold `dat_valid`=0 for 3 cycles during `OUT B` → no `io_wr` and no PC change. It then executes once when valid returns.
- HALT: `MOV A,3; HALT; MOV A,7` → A stays 3, `halted`=1, `adr` frozen. Asserting `rst` clears all state, and `adr`=0 on the next cycle.
- IN/MOV carry clear: `ADD A,0xF` with A=1 (C=1), then `IN B` with io_in=5 → B=5, C=0, Z=0.
